// File: rtl/demux8_rr_dispatcher_pkg.sv
// Shared definitions for the round-robin 1-to-8 dispatcher:
// channel count, select width and FSM state encoding.
package demux8_rr_dispatcher_pkg;

    localparam int NCH   = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/demux8_rr_dispatcher_if.sv
// Producer/consumer bundle of the dispatcher. The slave modport is the
// dispatcher's view; the master modport is the environment's view.
interface demux8_rr_dispatcher_if
    import demux8_rr_dispatcher_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);

    logic [NCH-1:0]   chan_en;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic [SEL_W-1:0] sel;
    logic [NCH-1:0]   out_valid;
    logic [WIDTH-1:0] out_data;
    logic [NCH-1:0]   out_ready;
    logic             busy;
    logic [CNT_W-1:0] disp_count;

    modport slave (
        input  chan_en, in_valid, in_data, out_ready,
        output in_ready, sel, out_valid, out_data, busy, disp_count
    );

    modport master (
        output chan_en, in_valid, in_data, out_ready,
        input  in_ready, sel, out_valid, out_data, busy, disp_count
    );

endinterface

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: first set mask bit at or after start,
// wrapping past channel 7 back to channel 0.
module rr_pick8
    import demux8_rr_dispatcher_pkg::*;
(
    input  logic [NCH-1:0]   mask,
    input  logic [SEL_W-1:0] start,
    output logic [SEL_W-1:0] idx,
    output logic             found
);

    logic [SEL_W-1:0] cand;

    // Scan from the farthest offset down so the nearest enabled channel wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            cand = start + SEL_W'(k);
            if (mask[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux8_rr_dispatcher.sv
// Latches one word at a time from the input stream and holds it on the next
// enabled output channel in rotating order until that channel accepts it.
module demux8_rr_dispatcher
    import demux8_rr_dispatcher_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
)(
    input  logic                   clk,
    input  logic                   rst_n,
    demux8_rr_dispatcher_if.slave  bus
);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] ptr_q,   ptr_d;
    logic [SEL_W-1:0] sel_q,   sel_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic [SEL_W-1:0] pick_idx;
    logic             pick_found;
    logic             in_ready_c;

    rr_pick8 u_pick (
        .mask  (bus.chan_en),
        .start (ptr_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    // pick_found is equivalent to a non-empty enable mask, so in_ready never
    // depends on in_valid; rst_n gating keeps it low while reset is asserted.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        sel_d      = sel_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        in_ready_c = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_c = rst_n & pick_found;
                if (bus.in_valid && pick_found) begin
                    data_d  = bus.in_data;
                    sel_d   = pick_idx;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready[sel_q]) begin
                    ptr_d   = sel_q + 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.busy       = (state_q == HOLD);
    assign bus.out_valid  = (state_q == HOLD) ? (NCH'(1) << sel_q) : '0;
    assign bus.sel        = sel_q;
    assign bus.out_data   = data_q;
    assign bus.disp_count = cnt_q;

endmodule

// File: tb/tb_demux8_rr_dispatcher.sv
// Randomized and directed bench for demux8_rr_dispatcher against a
// transaction-level round-robin reference model.
module tb_demux8_rr_dispatcher;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst_n;

    demux8_rr_dispatcher_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    demux8_rr_dispatcher #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: one word in flight, a rotating start channel, a count.
    bit m_hold;
    int m_ptr, m_sel, m_data, m_cnt;
    bit m_acc;
    int disp_q[$];

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    endtask

    function automatic int rr_target(input logic [7:0] en, input int start);
        for (int k = 0; k < 8; k++) begin
            if (en[(start + k) % 8]) return (start + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_hold = 0; m_ptr = 0; m_sel = 0; m_data = 0; m_cnt = 0; m_acc = 0;
        disp_q.delete();
    endtask

    // Called at posedge+1; checks mid-cycle, advances the model over the next edge.
    task automatic cycle();
        int  t;
        bit  n_hold, disp;
        int  n_sel, n_data;
        #4;
        check_val("in_ready", bus.in_ready, (!m_hold && bus.chan_en != 0));
        check_val("busy", bus.busy, m_hold);
        check_val("out_valid", bus.out_valid, m_hold ? (32'd1 << m_sel) : 32'd0);
        check_val("sel", bus.sel, m_sel);
        check_val("out_data", bus.out_data, m_data);
        check_val("disp_count", bus.disp_count, m_cnt);
        n_hold = m_hold; n_sel = m_sel; n_data = m_data; disp = 0;
        m_acc = 0;
        if (!m_hold) begin
            t = rr_target(bus.chan_en, m_ptr);
            if (bus.in_valid && t >= 0) begin
                n_hold = 1; n_sel = t; n_data = int'(bus.in_data); m_acc = 1;
            end
        end else if (bus.out_ready[m_sel]) begin
            disp = 1; n_hold = 0;
            disp_q.push_back(int'(bus.sel));
        end
        @(posedge clk);
        #1;
        if (disp) begin
            m_ptr = (m_sel + 1) % 8;
            m_cnt = (m_cnt + 1) % (1 << CNT_W);
        end
        m_hold = n_hold; m_sel = n_sel; m_data = n_data;
    endtask

    task automatic send_word(input logic [7:0] d);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        do begin
            cycle();
            n++;
        end while (!m_acc && n < 40);
        if (!m_acc) check_val("send_timeout", 32'd1, 32'd0);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (m_hold && n < 40) begin
            cycle();
            n++;
        end
        if (m_hold) check_val("drain_timeout", 32'd1, 32'd0);
    endtask

    // Entered at posedge+1; asserts reset between edges and checks it took effect at once.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rst_out_valid", bus.out_valid, 32'd0);
        check_val("rst_sel", bus.sel, 32'd0);
        check_val("rst_disp_count", bus.disp_count, 32'd0);
        check_val("rst_in_ready", bus.in_ready, 32'd0);
        check_val("rst_busy", bus.busy, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int exp_seq[$];
        rst_n = 1'b0;
        bus.chan_en = 8'hFF; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 8'h00;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // All channels enabled, consumer always ready
        bus.chan_en = 8'hFF; bus.out_ready = 8'hFF;
        for (int w = 0; w < 10; w++) send_word(8'(w));
        drain();
        check_val("all_en_count", bus.disp_count, 32'd10);
        exp_seq = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
        check_val("all_en_n", disp_q.size(), 32'd10);
        for (int i = 0; i < 10 && i < disp_q.size(); i++) check_val("all_en_sel", disp_q[i], exp_seq[i]);

        // Sparse mask
        do_reset();
        bus.chan_en = 8'b1010_0100; bus.out_ready = 8'hFF;
        for (int w = 0; w < 6; w++) send_word(8'h30 + 8'(w));
        drain();
        exp_seq = '{2, 5, 7, 2, 5, 7};
        check_val("sparse_n", disp_q.size(), 32'd6);
        for (int i = 0; i < 6 && i < disp_q.size(); i++) check_val("sparse_sel", disp_q[i], exp_seq[i]);

        // Backpressure on channel 3, other ready bits ignored
        do_reset();
        bus.chan_en = 8'h08; bus.out_ready = 8'h00;
        send_word(8'hA5);
        bus.chan_en = 8'hFF;
        for (int i = 0; i < 5; i++) cycle();
        bus.out_ready = 8'hF7;
        for (int i = 0; i < 3; i++) cycle();
        check_val("bp_held_valid", bus.out_valid, 32'h08);
        check_val("bp_held_data", bus.out_data, 32'hA5);
        bus.out_ready = 8'h08;
        cycle();
        bus.out_ready = 8'h00;
        cycle();
        check_val("bp_count", bus.disp_count, 32'd1);
        check_val("bp_n", disp_q.size(), 32'd1);

        // Mask change while holding on channel 4
        do_reset();
        bus.chan_en = 8'h10; bus.out_ready = 8'h00;
        send_word(8'h44);
        bus.chan_en = 8'hEF;
        cycle(); cycle();
        bus.out_ready = 8'hFF;
        drain();
        send_word(8'h55);
        drain();
        check_val("mask_n", disp_q.size(), 32'd2);
        if (disp_q.size() == 2) begin
            check_val("mask_first", disp_q[0], 32'd4);
            check_val("mask_next", disp_q[1], 32'd5);
        end
        bus.chan_en = 8'h00; bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        check_val("mask_zero_busy", bus.busy, 32'd0);
        bus.in_valid = 1'b0;

        // Asynchronous reset while holding
        bus.chan_en = 8'hFF; bus.out_ready = 8'h00;
        send_word(8'h77);
        check_val("pre_rst_busy", bus.busy, 32'd1);
        do_reset();
        bus.out_ready = 8'hFF;
        send_word(8'h78);
        drain();
        check_val("post_rst_n", disp_q.size(), 32'd1);
        if (disp_q.size() == 1) check_val("post_rst_chan", disp_q[0], 32'd0);

        // Counter wrap
        do_reset();
        bus.chan_en = 8'hFF; bus.out_ready = 8'hFF;
        for (int w = 0; w < 17; w++) send_word(8'(w * 3));
        drain();
        check_val("wrap_count", bus.disp_count, 32'd1);

        // Random traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bus.chan_en   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            bus.in_valid  = 1'($urandom);
            bus.in_data   = 8'($urandom);
            bus.out_ready = 8'($urandom);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
